// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED shift-register controller: frame width,
// controller state encoding and requester id.
package led_ctrl_pkg;

   localparam int FRAME_W = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      DONE     = 3'd4
   } state_t;

   typedef enum logic {
      ID_A = 1'b0,
      ID_B = 1'b1
   } gnt_id_t;

endpackage

// File: rtl/led_rr_arb.sv
// Two-way round-robin arbiter. A lone request is granted directly; when
// both requesters ask, the one not served last wins. After reset A has
// priority. The grant is committed when 'take' is high.
module led_rr_arb
   import led_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       take,
   output logic [1:0] gnt,
   output gnt_id_t    last_id
);

   logic    r_prio_b;
   gnt_id_t r_last_id;

   // One-hot grant: contention is resolved by the priority flag
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = r_prio_b ? 2'b10 : 2'b01;
      end
   end

   // Commit the grant: the side just served loses priority next time
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prio_b  <= 1'b0;
         r_last_id <= ID_A;
      end else if (take && (gnt != 2'b00)) begin
         r_prio_b  <= gnt[0];
         r_last_id <= gnt[1] ? ID_B : ID_A;
      end
   end

   assign last_id = r_last_id;

endmodule

// File: rtl/led_shift_ctrl.sv
// Serialises 16-bit frames from two requesters onto an LED shift-register
// chain (MSB first, inverted data line, chain captures on led_clk rise).
// Optional feature macro: LED_AUTO_REFRESH_EN -- periodically re-sends
// the last frame when the controller is idle.
// All outputs are flops loaded from the current-state decode, so every
// output trails the internal state by one clock.
module led_shift_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int CLK_DIV     = 4,
   parameter int REFRESH_CYC = 1000000
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_a,
   input  logic               req_b,
   input  logic [FRAME_W-1:0] data_a,
   input  logic [FRAME_W-1:0] data_b,
   output logic               ack_a,
   output logic               ack_b,
   output logic               busy,
   output logic               done,
   output logic               done_id,
   output logic               led_clk,
   output logic               led_dat,
   output logic               led_clr,
   output logic               led_en
);

   localparam logic [7:0] PRE_LD = 8'(CLK_DIV - 1);

   state_t             r_state, w_next;
   logic [7:0]         r_pre;
   logic [3:0]         r_bit;
   logic [FRAME_W-1:0] r_sreg;
   logic [1:0]         w_req, w_gnt;
   logic               w_take, w_refresh, w_pre_zero;
   logic [FRAME_W-1:0] w_ref_frame;
   gnt_id_t            w_last_id;
   logic               w_ack_a, w_ack_b, w_busy, w_done, w_led_clk, w_led_dat;

   assign w_req      = {req_b, req_a};
   assign w_take     = (r_state == IDLE) && (w_req != 2'b00);
   assign w_pre_zero = (r_pre == 8'd0);

   led_rr_arb u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (w_req),
      .take    (w_take),
      .gnt     (w_gnt),
      .last_id (w_last_id)
   );

`ifdef LED_AUTO_REFRESH_EN
   localparam int REF_W = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;

   logic [REF_W-1:0]   r_ref_cnt;
   logic               r_ref_pend;
   logic [FRAME_W-1:0] r_last_frame;
   logic               w_ref_tc;

   assign w_ref_tc    = (r_ref_cnt == REF_W'(REFRESH_CYC - 1));
   assign w_refresh   = (r_state == IDLE) && (w_req == 2'b00) && (r_ref_pend || w_ref_tc);
   assign w_ref_frame = r_last_frame;

   // Free-running refresh timer, pending flag, and copy of the last real frame
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ref_cnt    <= '0;
         r_ref_pend   <= 1'b0;
         r_last_frame <= '0;
      end else begin
         r_ref_cnt <= w_ref_tc ? '0 : r_ref_cnt + 1'b1;
         if (w_take || w_refresh) begin
            r_ref_pend <= 1'b0;
         end else if (w_ref_tc) begin
            r_ref_pend <= 1'b1;
         end
         if (w_take) begin
            r_last_frame <= w_gnt[1] ? data_b : data_a;
         end
      end
   end
`else
   logic [31:0] w_unused_refresh;

   assign w_unused_refresh = 32'(REFRESH_CYC);
   assign w_refresh        = 1'b0;
   assign w_ref_frame      = '0;
`endif

   // State register, per-state prescaler (reloaded on every entry) and bit counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pre   <= PRE_LD;
         r_bit   <= 4'd0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) begin
            r_pre <= PRE_LD;
         end else if (!w_pre_zero) begin
            r_pre <= r_pre - 8'd1;
         end
         if (r_state == LOAD) begin
            r_bit <= 4'd0;
         end else if ((r_state == SHIFT_HI) && w_pre_zero) begin
            r_bit <= r_bit + 4'd1;
         end
      end
   end

   // Frame shift register: load on accept or refresh, shift after each high phase
   always_ff @(posedge clk) begin
      if (w_take) begin
         r_sreg <= w_gnt[1] ? data_b : data_a;
      end else if (w_refresh) begin
         r_sreg <= w_ref_frame;
      end else if ((r_state == SHIFT_HI) && w_pre_zero) begin
         r_sreg <= {r_sreg[FRAME_W-2:0], 1'b0};
      end
   end

   // Next state and pre-register output decode; line idles high (logical 0)
   always_comb begin
      w_next    = r_state;
      w_ack_a   = 1'b0;
      w_ack_b   = 1'b0;
      w_busy    = 1'b0;
      w_done    = 1'b0;
      w_led_clk = 1'b1;
      w_led_dat = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_take || w_refresh) begin
               w_next  = LOAD;
               w_ack_a = w_take & w_gnt[0];
               w_ack_b = w_take & w_gnt[1];
            end
         end
         LOAD: begin
            w_busy = 1'b1;
            w_next = SHIFT_LO;
         end
         SHIFT_LO: begin
            w_busy    = 1'b1;
            w_led_clk = 1'b0;
            w_led_dat = ~r_sreg[FRAME_W-1];
            if (w_pre_zero) w_next = SHIFT_HI;
         end
         SHIFT_HI: begin
            w_busy    = 1'b1;
            w_led_dat = ~r_sreg[FRAME_W-1];
            if (w_pre_zero) w_next = (r_bit == 4'd15) ? DONE : SHIFT_LO;
         end
         DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Output registers; reset forces the chain into clear with the line idle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_a   <= 1'b0;
         ack_b   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= 1'b0;
         led_clk <= 1'b1;
         led_dat <= 1'b1;
         led_clr <= 1'b0;
         led_en  <= 1'b0;
      end else begin
         ack_a   <= w_ack_a;
         ack_b   <= w_ack_b;
         busy    <= w_busy;
         done    <= w_done;
         done_id <= logic'(w_last_id);
         led_clk <= w_led_clk;
         led_dat <= w_led_dat;
         led_clr <= 1'b1;
         led_en  <= 1'b1;
      end
   end

endmodule
